pmod_jstk_spi_ctrl: RTL and testbench
=====================================

Name: pmod_jstk_spi_ctrl

Overview:
- SPI master for the PmodJSTK joystick. It sits directly downstream of the 5 Hz clock divider.
- Each rising edge of the divider output (SNDREC) starts one 5-byte, SPI mode-0 transaction. The transaction sends the LED command and captures the joystick X/Y position and button state.
- Results are held stable between transactions for the display/game logic.

Parameters:
- SS_DLY, 1500: CLK cycles SS is held low before the first SCLK edge (15 us at 100 MHz).
- HALF_PER, 50: CLK cycles per SCLK half-period. The default gives 1 MHz SCLK. Minimum is 2.
- BYTE_GAP, 1000: CLK cycles of idle SCLK-low between consecutive bytes (10 us). Not inserted after byte 4.

Ports:
- CLK  in  1  system clock, 100 MHz
- RST  in  1  synchronous, active-high reset
- SNDREC  in  1  5 Hz trigger from the clock divider; rising edge starts a transaction
- LED_CMD  in  2  LED bits; sampled at transaction start
- MISO  in  1  SPI data from the joystick
- SS  out  1  SPI slave select, active low
- SCLK  out  1  SPI clock, idle low
- MOSI  out  1  SPI data to the joystick, MSB first
- BUSY  out  1  high from transaction start until DONE completes
- DATA_VALID  out  1  one-cycle pulse when JSTK_DATA updates
- JSTK_DATA  out  40  raw received bytes; byte0 is in [39:32], byte4 in [7:0]
- POS_X  out  10  {JSTK_DATA[25:24], JSTK_DATA[39:32]}
- POS_Y  out  10  {JSTK_DATA[9:8], JSTK_DATA[23:16]}
- BTNS  out  3  JSTK_DATA[2:0]

Behaviour:
- Reset (RST high at a CLK edge) takes effect at that edge, from any state including mid-transaction:
  - SS=1, SCLK=0, MOSI=0, BUSY=0, DATA_VALID=0, JSTK_DATA=0.
  - State goes to IDLE; all counters clear.
  - The SNDREC edge-detect register is set to 1, so a SNDREC level that is already high at reset release does not trigger.
- Edge detect: sndrec_q <= SNDREC every cycle. A start fires when SNDREC=1 and sndrec_q=0, in IDLE only. Edges that occur while BUSY=1 are dropped, not queued.
- Transmit bytes: byte0 = {6'b100000, LED_CMD} (LED_CMD latched at start); bytes 1–4 = 8'h00.
- State machine:
  - IDLE: SS=1, SCLK=0, BUSY=0.
    - On start: next cycle enters SETUP with SS=0, BUSY=1, MOSI = bit7 of byte0.
  - SETUP: hold SS low for exactly SS_DLY cycles, then go to XFER.
  - XFER: per bit, SCLK is low for HALF_PER cycles, then high for HALF_PER cycles.
    - MOSI changes only on the first cycle of the low phase; it holds the current bit MSB first.
    - MISO is sampled into the receive shift register on the cycle SCLK goes 0->1.
    - After bit 0, SCLK returns low.
    - If the byte index is <4, go to GAP. If it is 4, go to DONE.
  - GAP: SCLK=0 and SS=0 for BYTE_GAP cycles. MOSI presents bit7 of the next byte. Increment the byte index, then return to XFER.
  - DONE: a single cycle.
    - SS=1 and BUSY=0.
    - JSTK_DATA <= the receive shift register, and DATA_VALID=1.
    - Then return to IDLE. A start can be accepted the cycle after DONE.
- SS low duration per transaction is exactly SS_DLY + 80*HALF_PER + 4*BYTE_GAP cycles.
- Start-edge detection to SS low latency is 1 cycle.
- JSTK_DATA, POS_X, POS_Y and BTNS change only in DONE or on reset. They never change mid-transaction.
- Counters are sized for the parameters using clog2, with no wrap inside a phase. The byte index is 3 bits (0–4); the bit index is 3 bits (7 down to 0).
- SCLK is a registered output, never gated or derived combinationally from CLK.

Test Plan:
- Reset mid-transfer:
  - Stimulus: run with SS_DLY=4, HALF_PER=2, BYTE_GAP=3. Assert RST during byte 2.
  - Required: next cycle SS=1, SCLK=0, BUSY=0, JSTK_DATA=0. No DATA_VALID pulse. A fresh SNDREC edge then completes a full transaction normally.
- Basic transfer:
  - Stimulus: same small parameters, LED_CMD=2'b11. The MISO model returns bytes A5,03,5A,02,07.
  - Required: MOSI carries 83,00,00,00,00. SS is low for exactly 176 cycles. One DATA_VALID pulse with JSTK_DATA=40'hA5035A0207, POS_X=10'h3A5, POS_Y=10'h25A, BTNS=3'b111.
- Mode-0 timing check:
  - Required: MOSI never changes while SCLK=1. MISO is sampled only on SCLK rise. Exactly 40 SCLK rising edges per transaction. SCLK high and low phases are each HALF_PER cycles.
- Busy overlap:
  - Stimulus: pulse SNDREC low then high during XFER.
  - Required: the second edge is ignored. Exactly one DATA_VALID pulse results.
- Back-to-back:
  - Stimulus: present a SNDREC rising edge the cycle after DONE.
  - Required: SS goes low one cycle later, and the second transaction completes with the new data.
- Startup:
  - Stimulus: SNDREC held high through reset release.
  - Required: no transaction until SNDREC falls and rises again.

Source files
------------

// File: rtl/pmod_jstk_spi_ctrl.sv
// SPI mode-0 master for the PmodJSTK: one 5-byte exchange per SNDREC rising edge,
// sending the LED command and holding the received joystick bytes until the next exchange.
module pmod_jstk_spi_ctrl #(
  parameter int SS_DLY   = 1500,
  parameter int HALF_PER = 50,
  parameter int BYTE_GAP = 1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SNDREC,
  input  logic [1:0]  LED_CMD,
  input  logic        MISO,
  output logic        SS,
  output logic        SCLK,
  output logic        MOSI,
  output logic        BUSY,
  output logic        DATA_VALID,
  output logic [39:0] JSTK_DATA,
  output logic [9:0]  POS_X,
  output logic [9:0]  POS_Y,
  output logic [2:0]  BTNS,
  output logic [2:0]  fsm_state
);

  localparam int PER   = 2 * HALF_PER;
  localparam int TOP_A = (SS_DLY > PER) ? SS_DLY : PER;
  localparam int TOP   = (TOP_A > BYTE_GAP) ? TOP_A : BYTE_GAP;
  localparam int CW    = $clog2(TOP + 1);

  localparam logic [CW-1:0] SETUP_END = CW'(SS_DLY - 1);
  localparam logic [CW-1:0] RISE_AT   = CW'(HALF_PER - 1);
  localparam logic [CW-1:0] BIT_END   = CW'(PER - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(BYTE_GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_GAP, S_DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic [38:0]   tx;
  logic [39:0]   rx;
  logic          sndrec_q;
  logic          sclk_q;
  logic          mosi_q;

  logic start, setup_end, rise, bit_end, last_bit, gap_end;

  assign start     = (state == S_IDLE) && SNDREC && !sndrec_q;
  assign setup_end = (state == S_SETUP) && (cnt == SETUP_END);
  assign rise      = (state == S_XFER) && (cnt == RISE_AT);
  assign bit_end   = (state == S_XFER) && (cnt == BIT_END);
  assign last_bit  = bit_end && (bit_idx == 3'd0);
  assign gap_end   = (state == S_GAP) && (cnt == GAP_END);

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_SETUP;
      S_SETUP: if (setup_end) state_nx = S_XFER;
      S_XFER:  if (last_bit) state_nx = (byte_idx == 3'd4) ? S_DONE : S_GAP;
      S_GAP:   if (gap_end) state_nx = S_XFER;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // DATA_VALID is a one-cycle strobe with no ready; JSTK_DATA holds until the next strobe.
  always_comb begin
    SS         = !((state == S_SETUP) || (state == S_XFER) || (state == S_GAP));
    BUSY       = !SS;
    DATA_VALID = (state == S_DONE);
    SCLK       = sclk_q;
    MOSI       = mosi_q;
    fsm_state  = state;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sndrec_q  <= 1'b1;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      byte_idx  <= 3'd0;
      tx        <= '0;
      rx        <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      JSTK_DATA <= '0;
    end else begin
      sndrec_q <= SNDREC;
      case (state)
        S_IDLE: begin
          if (start) begin
            // Byte0 bit7 is always 1 and goes straight to MOSI; tx holds the remaining 39 bits.
            tx       <= {5'b00000, LED_CMD, 32'h0};
            mosi_q   <= 1'b1;
            cnt      <= '0;
            bit_idx  <= 3'd7;
            byte_idx <= 3'd0;
          end
        end
        S_SETUP: cnt <= setup_end ? '0 : cnt + CW'(1);
        S_XFER: begin
          if (rise) begin
            sclk_q <= 1'b1;
            rx     <= {rx[38:0], MISO};
          end
          if (bit_end) begin
            sclk_q  <= 1'b0;
            cnt     <= '0;
            tx      <= {tx[37:0], 1'b0};
            mosi_q  <= tx[38];
            bit_idx <= bit_idx - 3'd1;
            if (last_bit && (byte_idx == 3'd4)) JSTK_DATA <= rx;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (gap_end) begin
            cnt      <= '0;
            byte_idx <= byte_idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign POS_X = {JSTK_DATA[25:24], JSTK_DATA[39:32]};
  assign POS_Y = {JSTK_DATA[9:8], JSTK_DATA[23:16]};
  assign BTNS  = JSTK_DATA[2:0];

endmodule

// File: tb/tb_pmod_jstk_spi_ctrl.sv
// Bench for pmod_jstk_spi_ctrl: random joystick replies from a slave model, expectations
// queued at start and checked by a monitor on DATA_VALID and at the end of each SS-low window.
module tb_pmod_jstk_spi_ctrl;
  localparam int SS_DLY   = 4;
  localparam int HALF_PER = 2;
  localparam int BYTE_GAP = 3;
  localparam int SS_LEN   = SS_DLY + 80 * HALF_PER + 4 * BYTE_GAP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sndrec = 1'b1;
  logic [1:0]  led_cmd = 2'b00;
  logic        miso = 1'b0;
  logic        ss, sclk, mosi, busy, data_valid;
  logic [39:0] jstk_data;
  logic [9:0]  pos_x, pos_y;
  logic [2:0]  btns;
  logic [2:0]  fsm_state;

  pmod_jstk_spi_ctrl #(.SS_DLY(SS_DLY), .HALF_PER(HALF_PER), .BYTE_GAP(BYTE_GAP)) dut (
    .CLK(clk), .RST(rst), .SNDREC(sndrec), .LED_CMD(led_cmd), .MISO(miso),
    .SS(ss), .SCLK(sclk), .MOSI(mosi), .BUSY(busy), .DATA_VALID(data_valid),
    .JSTK_DATA(jstk_data), .POS_X(pos_x), .POS_Y(pos_y), .BTNS(btns), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [39:0] exp_q[$];
  logic [39:0] exp_mosi_q[$];
  logic [39:0] miso_data = '0;
  bit   abort_txn = 0;
  bit   mon_en = 0;
  int   dv_count = 0;
  int   mode_err = 0;
  int   stable_err = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // joystick slave: presents MSB first, advances after each SCLK fall
  int   miso_ptr = 39;
  logic s_prev_sclk = 1'b0;
  always @(negedge clk) begin
    if (ss === 1'b1) miso_ptr = 39;
    else if (s_prev_sclk && !sclk && miso_ptr > 0) miso_ptr--;
    miso = miso_data[miso_ptr];
    s_prev_sclk = sclk;
  end

  // monitor / scoreboard
  logic        p_ss = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;
  logic [39:0] p_jstk = '0;
  logic [39:0] mosi_cap = '0;
  logic [39:0] d;
  int ss_len = 0, rises = 0, high_len = 0, txn_err = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (data_valid) begin
        dv_count++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_dv: got pulse with data %0h expected none", jstk_data);
        end else begin
          d = exp_q.pop_front();
          check("jstk_data", jstk_data, d);
          check("pos_x", pos_x, {d[25:24], d[39:32]});
          check("pos_y", pos_y, {d[9:8], d[23:16]});
          check("btns", btns, d[2:0]);
        end
      end
      if (jstk_data !== p_jstk && !data_valid && !abort_txn) stable_err++;
      if (sclk && (mosi !== p_mosi)) mode_err++;
      if (sclk && ss) mode_err++;
      if (p_ss && !ss) begin
        ss_len = 0; rises = 0; high_len = 0; txn_err = 0; mosi_cap = '0;
      end
      if (!ss) begin
        ss_len++;
        if (sclk) high_len++;
        if (!p_sclk && sclk) begin
          if (ss_len != SS_DLY + HALF_PER + 1 + rises * 2 * HALF_PER + (rises / 8) * BYTE_GAP)
            txn_err++;
          mosi_cap = {mosi_cap[38:0], mosi};
          rises++;
        end
        if (p_sclk && !sclk) begin
          if (high_len != HALF_PER) txn_err++;
          high_len = 0;
        end
      end
      if (!p_ss && ss) begin
        if (abort_txn) abort_txn = 0;
        else begin
          if (high_len != HALF_PER) txn_err++;
          check("ss_low_len", ss_len, SS_LEN);
          check("sclk_rises", rises, 40);
          check("sclk_timing_errs", txn_err, 0);
          if (exp_mosi_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mosi_stream: got %0h expected no transaction", mosi_cap);
          end else check("mosi_stream", mosi_cap, exp_mosi_q.pop_front());
        end
      end
    end
    p_ss = ss; p_sclk = sclk; p_mosi = mosi; p_jstk = jstk_data;
  end

  // driver tasks
  task automatic start_txn(input logic [1:0] led, input logic [39:0] data);
    led_cmd = led;
    miso_data = data;
    sndrec = 1'b1;
    exp_q.push_back(data);
    exp_mosi_q.push_back({6'b100000, led, 32'h0});
    @(negedge clk);
    check("start_latency_ss", ss, 1'b0);
    sndrec = 1'b0;
  endtask

  task automatic wait_dv();
    int n = 0;
    while (!data_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!data_valid) begin
      errors++;
      $display("FAIL dv_timeout: got no DATA_VALID after %0d cycles expected a pulse", n);
    end
  endtask

  initial begin
    int dv_before;
    // startup: SNDREC held high through reset release
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1;
    check("rst_ss", ss, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_dv", data_valid, 1'b0);
    check("rst_jstk", jstk_data, 40'h0);
    repeat (30) @(negedge clk);
    check("startup_no_txn", {ss, busy}, 2'b10);
    sndrec = 1'b0;
    @(negedge clk);

    // basic transfer with fixed reply
    start_txn(2'b11, 40'hA5035A0207);
    wait_dv();
    check("basic_jstk", jstk_data, 40'hA5035A0207);
    check("basic_pos_x", pos_x, 10'h3A5);
    check("basic_pos_y", pos_y, 10'h25A);
    check("basic_btns", btns, 3'b111);

    // randomized transfers
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(1, 20)) @(negedge clk);
      start_txn(2'($urandom_range(0, 3)), {8'($urandom), $urandom});
      wait_dv();
    end

    // second SNDREC edge while busy must be dropped
    repeat (5) @(negedge clk);
    dv_before = dv_count;
    start_txn(2'b01, {8'($urandom), $urandom});
    repeat (60) @(negedge clk);
    sndrec = 1'b1;
    @(negedge clk);
    sndrec = 1'b0;
    wait_dv();
    repeat (250) @(negedge clk);
    check("overlap_dv_count", dv_count - dv_before, 1);

    // back-to-back: new edge in the cycle right after DONE
    start_txn(2'b10, {8'($urandom), $urandom});
    wait_dv();
    @(negedge clk);
    start_txn(2'b00, {8'($urandom), $urandom});
    wait_dv();

    // reset during byte 2
    repeat (3) @(negedge clk);
    start_txn(2'b11, {8'($urandom), $urandom});
    repeat (79) @(negedge clk);
    abort_txn = 1;
    exp_q.delete();
    exp_mosi_q.delete();
    dv_before = dv_count;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ss", ss, 1'b1);
    check("abort_sclk", sclk, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_jstk", jstk_data, 40'h0);
    check("abort_dv", data_valid, 1'b0);
    repeat (250) @(negedge clk);
    check("abort_no_dv", dv_count - dv_before, 0);
    start_txn(2'b01, {8'($urandom), $urandom});
    wait_dv();

    repeat (5) @(negedge clk);
    check("mode0_mosi_errs", mode_err, 0);
    check("data_stable_errs", stable_err, 0);
    check("pending_expect", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
